// File: rtl/seg7_scan_driver_pkg.sv
// Shared glyph constants for the seven-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; the driver inverts them for common-anode boards.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to seven-segment glyph decoder (active-high gfedcba).
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver: latches display data on a strobe and swaps it in only
// at frame boundaries so a frame never mixes old and new digits.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NDIGITS     = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        disp_data,
    input  logic               disp_load,
    input  logic [NDIGITS-1:0] dp_mask,
    output logic [NDIGITS-1:0] an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               frame_done
);

    localparam int  DATA_W = NDIGITS * 4;
    localparam int  DW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int  IW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam bit  INV    = (ACTIVE_LOW != 0);

    logic [DW-1:0]      div_cnt_q, div_cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  pending_q, pending_d;
    logic               pend_v_q, pend_v_d;
    logic               frame_done_q;
    logic [NDIGITS-1:0] an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               tc;
    logic               wrap;
    logic [3:0]         cur_nibble;
    logic [6:0]         glyph;
    logic               blank_sel;
    logic [NDIGITS-1:0] upper_zero;

    assign tc   = (div_cnt_q == DW'(REFRESH_DIV - 1));
    assign wrap = tc && (idx_q == IW'(NDIGITS - 1));

    // upper_zero[i] is set when digit i and everything above it is zero.
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_lz
            assign upper_zero[gi] = (shadow_q[DATA_W-1:gi*4] == '0);
        end
    endgenerate

    assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];
    assign blank_sel  = (BLANK_LZ != 0) && (idx_q != '0) && upper_zero[idx_q];

    hex_to_seg7 u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (glyph)
    );

    always_comb begin
        div_cnt_d = tc ? '0 : div_cnt_q + DW'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;

        if (tc) begin
            idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        // A load landing on the wrap cycle goes straight to the shadow and supersedes pending.
        if (wrap) begin
            if (disp_load) begin
                shadow_d = disp_data[DATA_W-1:0];
            end else if (pend_v_q) begin
                shadow_d = pending_q;
            end
            pend_v_d = 1'b0;
        end else if (disp_load) begin
            pending_d = disp_data[DATA_W-1:0];
            pend_v_d  = 1'b1;
        end

        an_d  = (NDIGITS'(1) << idx_q) ^ {NDIGITS{INV}};
        seg_d = (blank_sel ? SEG_BLANK : glyph) ^ {7{INV}};
        dp_d  = dp_mask[idx_q] ^ INV;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= {NDIGITS{INV}};
            seg_q        <= {7{INV}};
            dp_q         <= INV;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            frame_done_q <= wrap;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 8 digits, 4 clocks per digit, active-low, blanking on.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] disp_data = '0;
    logic        disp_load = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cap_an[8];
    logic [7:0] cap_an_end[8];
    logic [6:0] cap_seg[8];
    logic       cap_dp[8];
    logic       cap_fd_mid[8];
    logic       cap_fd_end;
    logic [6:0] exp_seg[8];

    seg7_scan_driver #(
        .NDIGITS     (8),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1),
        .BLANK_LZ    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_data  (disp_data),
        .disp_load  (disp_load),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Wait (bounded) until frame_done is seen on a falling edge.
    task automatic wait_frame(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s: frame_done not seen within 200 cycles", name);
        end
    endtask

    // Called just after a wrap edge; records one full frame and returns just after the next wrap edge.
    // Optionally pulses disp_load one cycle into the slot of digit load_at.
    task automatic capture_frame(input int load_at, input logic [31:0] val);
        for (int d = 0; d < 8; d++) begin
            @(posedge clk); #1;
            cap_an[d]     = an;
            cap_seg[d]    = seg;
            cap_dp[d]     = dp;
            cap_fd_mid[d] = frame_done;
            if (d == load_at) begin
                disp_data = val;
                disp_load = 1'b1;
                @(posedge clk); #1;
                disp_load = 1'b0;
                repeat (2) @(posedge clk);
            end else begin
                repeat (3) @(posedge clk);
            end
            #1;
            cap_an_end[d] = an;
        end
        cap_fd_end = frame_done;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: an=%h seg=%b dp=%b fd=%b expected an=ff seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        reset = 1'b0;
        wait_frame("first_frame");
    endtask

    task automatic test_scan;
        logic [7:0] exp_an;
        capture_frame(-1, 32'h0);
        exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 8; d++) begin
            exp_an = ~(8'h01 << d);
            vectors++;
            if (cap_an[d] !== exp_an || cap_an_end[d] !== exp_an) begin
                miscompares++;
                $display("FAIL scan_an digit %0d: an=%h/%h expected %h", d, cap_an[d], cap_an_end[d], exp_an);
            end
            vectors++;
            if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== 1'b1 || cap_fd_mid[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_seg digit %0d: seg=%b dp=%b fd=%b expected seg=%b dp=1 fd=0",
                         d, cap_seg[d], cap_dp[d], cap_fd_mid[d], exp_seg[d]);
            end
        end
        vectors++;
        if (cap_fd_end !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_period: frame_done=%b after 32 clks expected 1", cap_fd_end);
        end
    endtask

    task automatic test_load;
        capture_frame(0, 32'h12345678);
        exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 8; d++) begin
            vectors++;
            if (cap_seg[d] !== exp_seg[d]) begin
                miscompares++;
                $display("FAIL load_pending digit %0d: seg=%b expected %b", d, cap_seg[d], exp_seg[d]);
            end
        end
        capture_frame(-1, 32'h0);
        exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        for (int d = 0; d < 8; d++) begin
            vectors++;
            if (cap_seg[d] !== exp_seg[d]) begin
                miscompares++;
                $display("FAIL load_12345678 digit %0d: seg=%b expected %b", d, cap_seg[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_tear_free;
        capture_frame(3, 32'hFFFFFFFF);
        exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        for (int d = 0; d < 8; d++) begin
            vectors++;
            if (cap_seg[d] !== exp_seg[d]) begin
                miscompares++;
                $display("FAIL tear_old digit %0d: seg=%b expected %b", d, cap_seg[d], exp_seg[d]);
            end
        end
        capture_frame(-1, 32'h0);
        for (int d = 0; d < 8; d++) begin
            vectors++;
            if (cap_seg[d] !== 7'h0E) begin
                miscompares++;
                $display("FAIL tear_new digit %0d: seg=%b expected 0001110", d, cap_seg[d]);
            end
        end
    endtask

    task automatic test_blanking;
        logic exp_dp;
        dp_mask = 8'h84;
        capture_frame(0, 32'h000000A5);
        capture_frame(0, 32'h00050A00);
        exp_seg = '{7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 8; d++) begin
            exp_dp = !(d == 2 || d == 7);
            vectors++;
            if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== exp_dp) begin
                miscompares++;
                $display("FAIL blank_A5 digit %0d: seg=%b dp=%b expected seg=%b dp=%b",
                         d, cap_seg[d], cap_dp[d], exp_seg[d], exp_dp);
            end
        end
        dp_mask = 8'h00;
        capture_frame(-1, 32'h0);
        exp_seg = '{7'h40, 7'h40, 7'h08, 7'h40, 7'h12, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 8; d++) begin
            vectors++;
            if (cap_seg[d] !== exp_seg[d]) begin
                miscompares++;
                $display("FAIL blank_inner_zero digit %0d: seg=%b expected %b", d, cap_seg[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_last_write;
        disp_data = 32'h11;
        disp_load = 1'b1;
        @(posedge clk); #1;
        disp_data = 32'h22;
        @(posedge clk); #1;
        disp_load = 1'b0;
        wait_frame("last_write_frame");
        capture_frame(-1, 32'h0);
        exp_seg = '{7'h24, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 8; d++) begin
            vectors++;
            if (cap_seg[d] !== exp_seg[d]) begin
                miscompares++;
                $display("FAIL last_write digit %0d: seg=%b expected %b", d, cap_seg[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_wrap_load;
        disp_data = 32'h44;
        disp_load = 1'b1;
        @(posedge clk); #1;
        disp_load = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        disp_data = 32'h55;
        disp_load = 1'b1;
        @(posedge clk); #1;
        disp_load = 1'b0;
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_align: frame_done=%b expected 1", frame_done);
        end
        exp_seg = '{7'h12, 7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 32'h0);
            for (int d = 0; d < 8; d++) begin
                vectors++;
                if (cap_seg[d] !== exp_seg[d]) begin
                    miscompares++;
                    $display("FAIL wrap_load frame %0d digit %0d: seg=%b expected %b", f, d, cap_seg[d], exp_seg[d]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        dp_mask = 8'h20;
        repeat (22) @(posedge clk);
        #2;
        vectors++;
        if (an !== 8'hDF || seg !== 7'h7F || dp !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_digit5: an=%h seg=%b dp=%b expected an=df seg=1111111 dp=0", an, seg, dp);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: an=%h seg=%b dp=%b fd=%b expected an=ff seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        @(posedge clk); #1;
        vectors++;
        if (an !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_hold: an=%h expected ff", an);
        end
        reset = 1'b0;
        dp_mask = 8'h00;
        @(posedge clk); #1;
        vectors++;
        if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_digit0: an=%h seg=%b dp=%b expected an=fe seg=1000000 dp=1", an, seg, dp);
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_load;
        test_tear_free;
        test_blanking;
        test_last_write;
        test_wrap_load;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
